// File: rtl/axis_result_packer_if.sv
// rtl/axis_result_packer_if.sv - byte-lane stream bundle used on both sides of the result packer
interface axis_result_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]      tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_result_packer.sv
// rtl/axis_result_packer.sv - packs four 8-bit results per 32-bit stream word with TKEEP/TLAST framing
module axis_result_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int LANES      = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axis_result_packer_if.slave     s_axis,
    axis_result_packer_if.master    m_axis
);
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    // Lane counter doubles as the fill-state register.
    localparam logic [CNT_W-1:0] FILL0     = '0;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] merged;
    logic [LANES-1:0]      keep_next;
    logic [BYTE_WIDTH-1:0] in_byte;
    logic                  out_en;
    logic                  in_fire;
    logic                  out_fire;
    logic                  complete;
    logic                  unused_bits;

    assign in_byte     = s_axis.tdata[BYTE_WIDTH-1:0];
    assign unused_bits = ^{s_axis.tdata[DATA_WIDTH-1:BYTE_WIDTH], s_axis.tkeep};

    // out_en keeps tready low through reset and rises on the first edge after release.
    assign s_axis.tready = out_en & (~m_axis.tvalid | m_axis.tready);
    assign in_fire       = s_axis.tvalid & s_axis.tready;
    assign out_fire      = m_axis.tvalid & m_axis.tready;
    assign complete      = in_fire & ((cnt == FILL_LAST) | s_axis.tlast);

    always_comb begin
        merged    = acc;
        keep_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == cnt)
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = in_byte;
            if (CNT_W'(i) <= cnt)
                keep_next[i] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            out_en        <= 1'b0;
            cnt           <= FILL0;
            acc           <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
        end else begin
            out_en <= 1'b1;
            if (out_fire)
                m_axis.tvalid <= 1'b0;
            if (in_fire) begin
                if (complete) begin
                    // A completing beat overrides the drain so the register reloads with no bubble.
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= merged;
                    m_axis.tkeep  <= keep_next;
                    m_axis.tlast  <= s_axis.tlast;
                    cnt           <= FILL0;
                    acc           <= '0;
                end else begin
                    acc <= merged;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_result_packer.sv
// tb/tb_axis_result_packer.sv - randomized bench for axis_result_packer against a byte-queue model
module tb_axis_result_packer;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axis_result_packer_if #(.DATA_WIDTH(32), .LANES(4)) s_if ();
    axis_result_packer_if #(.DATA_WIDTH(32), .LANES(4)) m_if ();

    axis_result_packer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .LANES(4)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;

    beat_t      beats_q[$];
    word_t      exp_q[$];
    word_t      obs_q[$];
    logic [7:0] part_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: gather accepted bytes; emit a word at 4 bytes or at frame end.
    task automatic model_accept(input beat_t b);
        word_t w;
        part_q.push_back(b.data[7:0]);
        if (part_q.size() == 4 || b.last) begin
            w.data = 32'h0;
            foreach (part_q[i]) w.data = w.data | (32'(part_q[i]) << (8 * i));
            w.keep = 4'((1 << part_q.size()) - 1);
            w.last = b.last;
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    task automatic add_beat(input logic [31:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        beats_q.push_back(b);
    endtask

    task automatic run(input int valid_pct, input int ready_mode, input int budget);
        int    c = 0;
        logic  pv = 1'b0;
        word_t pw, w, e;
        obs_q.delete();
        stalls = 0;
        while ((beats_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
            @(negedge ACLK);
            if (pv) begin
                check("hold_valid", 32'(m_if.tvalid), 32'h1);
                check("hold_data", m_if.tdata, pw.data);
                check("hold_keep", 32'(m_if.tkeep), 32'(pw.keep));
                check("hold_last", 32'(m_if.tlast), 32'(pw.last));
            end
            s_if.tvalid = (beats_q.size() > 0) && ($urandom_range(99) < valid_pct);
            if (beats_q.size() > 0) begin
                s_if.tdata = beats_q[0].data;
                s_if.tlast = beats_q[0].last;
            end else begin
                s_if.tdata = $urandom;
                s_if.tlast = 1'b0;
            end
            case (ready_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (c % 3 == 0);
                default: m_if.tready = 1'($urandom_range(1));
            endcase
            #1;
            check("s_tready", 32'(s_if.tready), 32'(!m_if.tvalid || m_if.tready));
            if (s_if.tvalid && !s_if.tready) stalls++;
            w.data = m_if.tdata;
            w.keep = m_if.tkeep;
            w.last = m_if.tlast;
            if (m_if.tvalid && m_if.tready) begin
                obs_q.push_back(w);
                if (exp_q.size() == 0) begin
                    check("extra_word", m_if.tdata, 32'h0 ^ ~m_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", w.data, e.data);
                    check("word_keep", 32'(w.keep), 32'(e.keep));
                    check("word_last", 32'(w.last), 32'(e.last));
                end
            end
            pv = m_if.tvalid && !m_if.tready;
            pw = w;
            if (s_if.tvalid && s_if.tready) model_accept(beats_q.pop_front());
            c++;
        end
        s_if.tvalid = 1'b0;
        check("drain", 32'(beats_q.size() + exp_q.size()), 32'h0);
    endtask

    task automatic frame_seq64();
        for (int i = 0; i < 64; i++) add_beat({$urandom} & 32'hFFFF_FF00 | 32'(i), i == 63);
    endtask

    task automatic frame_a1();
        for (int i = 0; i < 5; i++) add_beat(32'hA1 + 32'(i), i == 4);
    endtask

    task automatic check_a1();
        check("a1_words", 32'(obs_q.size()), 32'd2);
        check("a1_w0", obs_q[0].data, 32'hA4A3A2A1);
        check("a1_k0", 32'(obs_q[0].keep), 32'hF);
        check("a1_l0", 32'(obs_q[0].last), 32'h0);
        check("a1_w1", obs_q[1].data, 32'h000000A5);
        check("a1_k1", 32'(obs_q[1].keep), 32'h1);
        check("a1_l1", 32'(obs_q[1].last), 32'h1);
    endtask

    initial begin
        int nlast;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'h0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = 4'hF;
        m_if.tready = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_if.tvalid), 32'h0);
        check("rst_tdata", m_if.tdata, 32'h0);
        check("rst_tkeep", 32'(m_if.tkeep), 32'h0);
        check("rst_tlast", 32'(m_if.tlast), 32'h0);
        check("rst_tready", 32'(s_if.tready), 32'h0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        check("rel_tready", 32'(s_if.tready), 32'h1);

        frame_seq64();
        run(100, 0, 300);
        check("t1_words", 32'(obs_q.size()), 32'd16);
        check("t1_first", obs_q[0].data, 32'h03020100);
        check("t1_last", obs_q[15].data, 32'h3F3E3D3C);
        check("t1_stalls", 32'(stalls), 32'h0);
        nlast = 0;
        foreach (obs_q[i]) if (obs_q[i].last) nlast++;
        check("t1_nlast", 32'(nlast), 32'h1);

        frame_a1();
        run(100, 0, 100);
        check_a1();

        frame_seq64();
        run(100, 1, 1000);
        check("t3_words", 32'(obs_q.size()), 32'd16);
        check("t3_first", obs_q[0].data, 32'h03020100);
        check("t3_last", obs_q[15].data, 32'h3F3E3D3C);

        add_beat(32'hFFFFFF07, 1'b0);
        add_beat(32'hDEAD0008, 1'b1);
        run(100, 0, 100);
        check("t4_data", obs_q[0].data, 32'h00000807);
        check("t4_keep", 32'(obs_q[0].keep), 32'h3);
        check("t4_last", 32'(obs_q[0].last), 32'h1);

        for (int i = 0; i < 6; i++) add_beat(32'h50 + 32'(i), 1'b0);
        run(100, 0, 100);
        check("t5_pre_words", 32'(obs_q.size()), 32'd1);
        check("t5_pre_data", obs_q[0].data, 32'h53525150);
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        check("t5_rst_tvalid", 32'(m_if.tvalid), 32'h0);
        check("t5_rst_tready", 32'(s_if.tready), 32'h0);
        check("t5_rst_tkeep", 32'(m_if.tkeep), 32'h0);
        part_q.delete();
        exp_q.delete();
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check("t5_rel_tready0", 32'(s_if.tready), 32'h0);
        @(posedge ACLK);
        #1;
        check("t5_rel_tready1", 32'(s_if.tready), 32'h1);
        frame_a1();
        run(100, 0, 100);
        check_a1();

        for (int i = 0; i < 3; i++) add_beat(32'h10 + 32'(i), i == 2);
        for (int i = 0; i < 4; i++) add_beat(32'h20 + 32'(i), i == 3);
        run(100, 0, 100);
        check("t6_words", 32'(obs_q.size()), 32'd2);
        check("t6_d0", obs_q[0].data, 32'h00121110);
        check("t6_k0", 32'(obs_q[0].keep), 32'h7);
        check("t6_l0", 32'(obs_q[0].last), 32'h1);
        check("t6_d1", obs_q[1].data, 32'h23222120);
        check("t6_k1", 32'(obs_q[1].keep), 32'hF);
        check("t6_l1", 32'(obs_q[1].last), 32'h1);

        for (int f = 0; f < 20; f++) begin
            int len;
            len = int'($urandom_range(12, 1));
            for (int i = 0; i < len; i++) add_beat($urandom, i == len - 1);
        end
        run(70, 2, 5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
